// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the 6502 boot ROM arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Optional round-robin arbitration is selected with ROM_ARB_ROUND_ROBIN_EN.
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
    endfunction

endpackage

// File: rtl/rom_arb_picker.sv
// Winner select between CPU and debug requests; ROM_ARB_ROUND_ROBIN_EN picks tie policy.
// Latency: combinational, consumed by the arbiter FSM only while idle.
// Backpressure: none; a losing request simply stays asserted until granted.
module rom_arb_picker
    import rom_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_t last_owner,
    output logic   grant_vld,
    output owner_t grant
);

`ifndef ROM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_vld = cpu_req | dbg_req;
        grant     = OWN_CPU;
        if (cpu_req && dbg_req) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            grant = other_owner(last_owner);
`else
            grant = OWN_CPU;
`endif
        end else if (dbg_req) begin
            grant = OWN_DBG;
        end
    end

endmodule

// File: rtl/rom_6502_arbiter.sv
// Shares the single-port 6502 boot ROM between CPU fetch and host/debug ports (ROM_ARB_ROUND_ROBIN_EN: fair ties).
// Latency: ack one clock after req is sampled, rdata/valid three clocks after that ack edge.
// Backpressure: one access in flight; requests hold until ack, WAIT holds until rom_valid.
module rom_6502_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_oe,
    input  logic              rom_valid,
    input  logic [DATA_W-1:0] rom_q
);

    state_t              state;
    owner_t              owner;
    logic                grant_vld;
    owner_t              grant;
    logic                resp_pend;
    logic [DATA_W-1:0]   resp_dat;

    rom_arb_picker u_picker (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (owner),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_DBG;
            resp_pend   <= 1'b0;
            resp_dat    <= '0;
            rom_address <= '0;
            rom_oe      <= 1'b0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_valid   <= 1'b0;
            dbg_valid   <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
        end else begin
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_valid <= 1'b0;
            dbg_valid <= 1'b0;
            rom_oe    <= 1'b0;
            resp_pend <= 1'b0;

            // Response delivery reads the owner before a same-edge re-arbitration overwrites it.
            if (resp_pend) begin
                if (owner == OWN_CPU) begin
                    cpu_valid <= 1'b1;
                    cpu_rdata <= resp_dat;
                end else begin
                    dbg_valid <= 1'b1;
                    dbg_rdata <= resp_dat;
                end
            end

            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        rom_address <= (grant == OWN_CPU) ? cpu_addr : dbg_addr;
                        cpu_ack     <= (grant == OWN_CPU);
                        dbg_ack     <= (grant == OWN_DBG);
                        owner       <= grant;
                        rom_oe      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rom_valid) begin
                        resp_dat  <= rom_q;
                        resp_pend <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_6502_arbiter.sv
// Self-checking bench for rom_6502_arbiter with a behavioural ROM (q and valid one clock after oe).
module tb_rom_6502_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ack, cpu_valid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_ack, dbg_valid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] rom_address;
    logic          rom_oe;
    logic          rom_valid = 1'b0;
    logic [DW-1:0] rom_q = '0;

    logic [DW-1:0] mem [0:4095];
    logic          rom_stall = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cpu_vcnt = 0;
    int dbg_vcnt = 0;
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] dbg_exp_q[$];
    int cpu_ack_t[$];
    int dbg_ack_t[$];

    rom_6502_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_valid   (cpu_valid),
        .cpu_rdata   (cpu_rdata),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_valid   (dbg_valid),
        .dbg_rdata   (dbg_rdata),
        .rom_address (rom_address),
        .rom_oe      (rom_oe),
        .rom_valid   (rom_valid),
        .rom_q       (rom_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_valid <= rom_oe && !rom_stall;
        if (rom_oe) rom_q <= mem[rom_address];
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[12'h000] = 8'h4C;
        mem[12'h001] = 8'h09;
        mem[12'h002] = 8'hC0;
        mem[12'h003] = 8'hAD;
        mem[12'h009] = 8'hA9;
        mem[12'hFFC] = 8'h00;
    end

    // Scoreboard: data and ack-to-valid latency for every response.
    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_ack) cpu_ack_t.push_back(cyc);
            if (dbg_ack) dbg_ack_t.push_back(cyc);
            if (cpu_valid) begin
                logic [DW-1:0] e;
                int t;
                cpu_vcnt++;
                total++;
                if (cpu_exp_q.size() == 0 || cpu_ack_t.size() == 0) begin
                    bad++;
                    $display("FAIL cpu_unexpected_valid rdata=%h none expected", cpu_rdata);
                end else begin
                    e = cpu_exp_q.pop_front();
                    t = cpu_ack_t.pop_front();
                    if (cpu_rdata !== e) begin
                        bad++;
                        $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, e);
                    end
                    total++;
                    if (cyc - t !== 3) begin
                        bad++;
                        $display("FAIL cpu_latency got=%0d exp=3", cyc - t);
                    end
                end
            end
            if (dbg_valid) begin
                logic [DW-1:0] e;
                int t;
                dbg_vcnt++;
                total++;
                if (dbg_exp_q.size() == 0 || dbg_ack_t.size() == 0) begin
                    bad++;
                    $display("FAIL dbg_unexpected_valid rdata=%h none expected", dbg_rdata);
                end else begin
                    e = dbg_exp_q.pop_front();
                    t = dbg_ack_t.pop_front();
                    if (dbg_rdata !== e) begin
                        bad++;
                        $display("FAIL dbg_rdata got=%h exp=%h", dbg_rdata, e);
                    end
                    total++;
                    if (cyc - t !== 3) begin
                        bad++;
                        $display("FAIL dbg_latency got=%0d exp=3", cyc - t);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit dbg, input logic [AW-1:0] a, input int limit,
                          output bit got, output int t);
        if (dbg) begin
            dbg_addr = a;
            dbg_req  = 1'b1;
            dbg_exp_q.push_back(mem[a]);
        end else begin
            cpu_addr = a;
            cpu_req  = 1'b1;
            cpu_exp_q.push_back(mem[a]);
        end
        got = 1'b0;
        t = -1;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            got = dbg ? dbg_ack : cpu_ack;
        end
        if (got) t = cyc;
        else if (dbg) void'(dbg_exp_q.pop_back());
        else void'(cpu_exp_q.pop_back());
        if (dbg) dbg_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (cpu_exp_q.size() != 0 || dbg_exp_q.size() != 0); i++)
            @(negedge clk);
        total++;
        if (cpu_exp_q.size() != 0 || dbg_exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending cpu=%0d dbg=%0d exp=0", cpu_exp_q.size(), dbg_exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit got;
        int t;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cpu_ack, cpu_valid, cpu_rdata, dbg_ack, dbg_valid, dbg_rdata, rom_address, rom_oe} !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {cpu_ack, cpu_valid, cpu_rdata, dbg_ack, dbg_valid, dbg_rdata, rom_address, rom_oe});
        end
        @(negedge clk);
        reset_n = 1'b1;
        rom_stall = 1'b1;
        do_req(1'b0, 12'h123, 5, got, t);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL reset_pre_ack got=%b exp=1", got); end
        repeat (3) @(negedge clk);
        total++;
        if (rom_address !== 12'h123) begin bad++; $display("FAIL wait_address got=%h exp=123", rom_address); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({cpu_ack, cpu_valid, cpu_rdata, dbg_ack, dbg_valid, dbg_rdata, rom_address, rom_oe} !== 33'd0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%h exp=0",
                     {cpu_ack, cpu_valid, cpu_rdata, dbg_ack, dbg_valid, dbg_rdata, rom_address, rom_oe});
        end
        cpu_exp_q.delete();
        cpu_ack_t.delete();
        dbg_exp_q.delete();
        dbg_ack_t.delete();
        rom_stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_req(1'b0, 12'h000, 1, got, t);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL reset_idle_ack got=%b exp=1", got); end
        drain();
    endtask

    task automatic test_cpu_read();
        bit got;
        int t;
        logic [DW-1:0] dprev;
        int dv0;
        dprev = dbg_rdata;
        dv0 = dbg_vcnt;
        do_req(1'b0, 12'h000, 5, got, t);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL cpu_ack got=%b exp=1", got); end
        total++;
        if ({rom_oe, rom_address} !== {1'b1, 12'h000}) begin
            bad++; $display("FAIL issue_oe_addr got=%b/%h exp=1/000", rom_oe, rom_address);
        end
        @(negedge clk);
        total++;
        if ({rom_oe, cpu_ack} !== 2'b00) begin bad++; $display("FAIL oe_ack_pulse got=%b exp=00", {rom_oe, cpu_ack}); end
        @(negedge clk);
        total++;
        if (cpu_valid !== 1'b0) begin bad++; $display("FAIL cpu_valid_early got=%b exp=0", cpu_valid); end
        @(negedge clk);
        total++;
        if ({cpu_valid, cpu_rdata} !== {1'b1, 8'h4C}) begin
            bad++; $display("FAIL cpu_read_e3 got=%b/%h exp=1/4c", cpu_valid, cpu_rdata);
        end
        total++;
        if (dbg_rdata !== dprev || dbg_vcnt !== dv0) begin
            bad++; $display("FAIL dbg_untouched got=%h/%0d exp=%h/%0d", dbg_rdata, dbg_vcnt, dprev, dv0);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        bit gc, gd;
        int tc, td;
        fork
            do_req(1'b0, 12'hFFC, 20, gc, tc);
            do_req(1'b1, 12'h009, 20, gd, td);
        join
        total++;
        if ({gc, gd} !== 2'b11) begin bad++; $display("FAIL tie_acks got=%b exp=11", {gc, gd}); end
`ifdef ROM_ARB_ROUND_ROBIN_EN
        total++;
        if (tc - td !== 3) begin bad++; $display("FAIL tie_order cpu-dbg got=%0d exp=3", tc - td); end
`else
        total++;
        if (td - tc !== 3) begin bad++; $display("FAIL tie_order dbg-cpu got=%0d exp=3", td - tc); end
`endif
        drain();
        total++;
        if ({cpu_rdata, dbg_rdata} !== {8'h00, 8'hA9}) begin
            bad++; $display("FAIL tie_data got=%h/%h exp=00/a9", cpu_rdata, dbg_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bit g;
        int tt[4];
        int v0;
        v0 = cpu_vcnt;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, AW'(i), 20, g, tt[i]);
            total++;
            if (g !== 1'b1) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=1", i, g); end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (tt[i] - tt[i-1] !== 3) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=3", i, tt[i] - tt[i-1]); end
        end
        drain();
        total++;
        if (cpu_vcnt - v0 !== 4 || cpu_rdata !== 8'hAD) begin
            bad++; $display("FAIL b2b_count got=%0d/%h exp=4/ad", cpu_vcnt - v0, cpu_rdata);
        end
    endtask

    task automatic test_addr_change();
        bit g;
        int t;
        do_req(1'b0, 12'h002, 20, g, t);
        cpu_addr = 12'h003;
        total++;
        if (g !== 1'b1) begin bad++; $display("FAIL latch_ack got=%b exp=1", g); end
        drain();
        total++;
        if (cpu_rdata !== 8'hC0) begin bad++; $display("FAIL latch_data got=%h exp=c0", cpu_rdata); end
    endtask

    task automatic test_starvation();
        bit gd;
        int td;
        int ok;
        ok = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bit g;
                    int t;
                    do_req(1'b0, 12'h010 + AW'(i), 30, g, t);
                    if (g) ok++;
                end
            end
            begin
                @(negedge clk);
`ifdef ROM_ARB_ROUND_ROBIN_EN
                do_req(1'b1, 12'h009, 6, gd, td);
`else
                do_req(1'b1, 12'h009, 12, gd, td);
`endif
            end
        join
`ifdef ROM_ARB_ROUND_ROBIN_EN
        total++;
        if (gd !== 1'b1) begin bad++; $display("FAIL rr_dbg_served got=%b exp=1", gd); end
`else
        total++;
        if (gd !== 1'b0) begin bad++; $display("FAIL prio_dbg_starved got=%b exp=0", gd); end
`endif
        total++;
        if (ok !== 6) begin bad++; $display("FAIL stream_cpu_acks got=%0d exp=6", ok); end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_back_to_back();
        test_addr_change();
        test_starvation();
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
